pl_kernel_hls_deadlock_report_ctrl: RTL and testbench
=====================================================

# pl_kernel_hls_deadlock_report_ctrl

Central controller at the kernel's top level, on the opposite side of the deadlock-detection network from the per-process detection units. It collects every unit's deadlock flag and latches the first detection. It then broadcasts the detection back to all units and injects a trace token at one origin process. It follows the token around the dependency cycle, clears it when the cycle closes, and streams the IDs of the involved processes out through a small FIFO for the host or debug logic.

## Interface
Parameters:
- PROC_NUM, 4, number of detection units (processes); ≥ 2
- ID_W, 2, process-ID width; equals max(1, clog2(PROC_NUM))
- FIFO_DEPTH, 8, report FIFO entries; power of 2, ≥ PROC_NUM
- TIMEOUT, 64, max idle cycles without a visible token while tracing

Ports:
- reset  input  1  asynchronous, active-low
- clock  input  1  clock
- dl_in_vec  input  PROC_NUM  bit p = dl_detect_out of unit p
- token_vec  input  PROC_NUM  bit p = OR of unit p's token_in_vec (token present at p)
- dl_detect  output  1  broadcast to every unit's dl_detect_in; registered
- origin  output  PROC_NUM  one-hot; bit p drives unit p's origin; registered
- token_clear  output  1  broadcast to every unit's token_clear; combinational
- report_valid  output  1  report FIFO not empty
- report_ready  input  1  consumer accepts the head entry
- report_id  output  ID_W  process ID at the FIFO head
- report_last  output  1  head entry closes the trace
- trace_done  output  1  sticky; trace finished
- err_multi_token  output  1  sticky; more than one token_vec bit was set
- err_timeout  output  1  sticky; TIMEOUT expired while tracing
- err_overflow  output  1  sticky; write attempted while the FIFO was full

## Operation
FSM states: IDLE, ORIGIN, TRACE, DONE.
- **IDLE**
  - All outputs are low.
  - If |dl_in_vec, capture o = lowest set index and go to ORIGIN.
  - Push o to the FIFO with last=0.
- **ORIGIN** (lasts one cycle)
  - dl_detect=1 (held from here until reset).
  - origin = 1<<o for exactly this cycle.
  - Clear the timeout counter and go to TRACE.
- **TRACE**
  - When |token_vec: h = lowest set index. If popcount(token_vec) > 1, set err_multi_token.
  - If dl_in_vec[h] & token_vec[h], the cycle is closed:
    - assert token_clear in this same cycle (combinational: state==TRACE & |(dl_in_vec & token_vec));
    - push h with last=1;
    - set trace_done and go to DONE.
  - Otherwise push h with last=0 and reset the timeout counter.
  - When token_vec==0, increment the timeout counter.
    - When it reaches TIMEOUT-1, set err_timeout and trace_done, and go to DONE.
    - Push nothing in this case; the final entry's last bit then remains 0.
  - Length cap: the trace holds at most 2·PROC_NUM pushes, counting the IDLE-state push of o. If the cap is hit without closure, set err_timeout and trace_done, and go to DONE.
- **DONE**
  - Hold dl_detect=1; origin=0; token_clear=0.
  - Ignore dl_in_vec and token_vec.
  - Leave DONE only on reset.
- **FIFO**
  - Entry = {last, id}.
  - Pop when report_valid & report_ready.
  - A push while full (and no pop in the same cycle) is dropped and sets err_overflow.
  - Simultaneous push and pop while full is legal.
  - Pointers are ID-agnostic and wrap modulo FIFO_DEPTH, with an extra wrap bit for the full/empty test.

## Timing
- Reset values:
  - dl_detect=0, origin=0, token_clear=0, report_valid=0;
  - report_id=0, report_last=0;
  - all sticky flags 0; state=IDLE; FIFO empty.
- Cycle sequence (t0 = the cycle |dl_in_vec is first seen in IDLE):
  - t0: entry o is written at the clock edge ending t0; report_valid=1 from t0+1.
  - t0+1: ORIGIN state; dl_detect and origin are high.
  - t0+2: the unit's registered token_out produces token_vec at the next process. This is the first possible TRACE observation.
- Per-hop latency: one cycle per token hop; each observed hop is pushed at the edge ending that cycle.
- Any pending dl_in_vec in ORIGIN is ignored; the origin is chosen once.
- report_id/report_last are valid whenever report_valid=1 and remain stable until popped.
- Reset asserted mid-trace immediately clears the FSM, FIFO, flags and outputs. No partial report survives.

## Test plan
- **Reset:** hold reset=0 with dl_in_vec=4'b1111 → all outputs 0 and state IDLE; after release the trace starts at o=0.
- **Three-process cycle (PROC_NUM=4):**
  - stimulus: dl_in_vec=4'b0100 at t0, origin=4'b0100 at t0+1; token_vec=4'b0010 at t0+2, 4'b1000 at t0+3, then 4'b0100 with dl_in_vec[2]=1 at t0+4;
  - response: token_clear=1 only in t0+4; FIFO reads 2,1,3,2 with last=1 only on the final 2; trace_done=1 from t0+5.
- **Multi-token:** token_vec=4'b0011 in TRACE → h=0 pushed, err_multi_token=1.
- **Timeout (TIMEOUT=8):** token_vec stays 0 after ORIGIN → err_timeout and trace_done set after 8 idle TRACE cycles; FIFO holds only the origin entry, with last=0.
- **Backpressure (FIFO_DEPTH=4):** report_ready=0 through a 6-push trace → exactly 4 entries held and err_overflow=1; with report_ready=1 during a push while full, nothing is lost.

Source files
------------

// File: rtl/pl_kernel_hls_deadlock_report_ctrl.sv
// Top-level deadlock report controller: latches the first detection, injects a trace
// token at the origin process, follows it around the cycle and queues involved IDs.
module pl_kernel_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM   = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic                dl_detect,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [ID_W-1:0]     report_id,
  output logic                report_last,
  output logic                trace_done,
  output logic                err_multi_token,
  output logic                err_timeout,
  output logic                err_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int PUSH_W = $clog2(2 * PROC_NUM) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ORIGIN = 2'd1,
    TRACE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic logic multi_hot(input logic [PROC_NUM-1:0] v);
    multi_hot = |(v & (v - PROC_NUM'(1)));
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [PUSH_W-1:0]   pushes_r, pushes_s;
  logic [PROC_NUM-1:0] origin_s;
  logic [ID_W-1:0]     hop_s;
  logic                push_s, push_last_s;
  logic [ID_W-1:0]     push_id_s;
  logic                set_multi_s, set_timeout_s, set_done_s;

  logic [ID_W:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_r, rd_ptr_r;
  logic                empty_s, full_s, pop_s, wr_en_s, drop_s;

  assign hop_s       = lowest_idx(token_vec);
  assign token_clear = (state_r == TRACE) & (|(dl_in_vec & token_vec));

  // Next-state, push request and flag-set decode
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    pushes_s      = pushes_r;
    origin_s      = '0;
    push_s        = 1'b0;
    push_last_s   = 1'b0;
    push_id_s     = '0;
    set_multi_s   = 1'b0;
    set_timeout_s = 1'b0;
    set_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|dl_in_vec) begin
          push_s    = 1'b1;
          push_id_s = lowest_idx(dl_in_vec);
          origin_s  = PROC_NUM'(1) << lowest_idx(dl_in_vec);
          pushes_s  = PUSH_W'(1);
          state_s   = ORIGIN;
        end else begin
          state_s = IDLE;
        end
      end
      ORIGIN: begin
        cnt_s   = '0;
        state_s = TRACE;
      end
      TRACE: begin
        if (|token_vec) begin
          set_multi_s = multi_hot(token_vec);
          push_s      = 1'b1;
          push_id_s   = hop_s;
          cnt_s       = '0;
          pushes_s    = pushes_r + PUSH_W'(1);
          if (dl_in_vec[hop_s]) begin
            push_last_s = 1'b1;
            set_done_s  = 1'b1;
            state_s     = DONE;
          end else if (pushes_r == PUSH_W'(2 * PROC_NUM - 1)) begin
            // this push fills the length cap without the cycle closing
            set_timeout_s = 1'b1;
            set_done_s    = 1'b1;
            state_s       = DONE;
          end else begin
            state_s = TRACE;
          end
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          set_timeout_s = 1'b1;
          set_done_s    = 1'b1;
          state_s       = DONE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Controller state, counters and registered broadcast outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      pushes_r  <= '0;
      dl_detect <= 1'b0;
      origin    <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pushes_r  <= pushes_s;
      dl_detect <= (state_s != IDLE);
      origin    <= origin_s;
    end
  end

  // Sticky status flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_done      <= 1'b0;
      err_multi_token <= 1'b0;
      err_timeout     <= 1'b0;
      err_overflow    <= 1'b0;
    end else begin
      trace_done      <= trace_done | set_done_s;
      err_multi_token <= err_multi_token | set_multi_s;
      err_timeout     <= err_timeout | set_timeout_s;
      err_overflow    <= err_overflow | drop_s;
    end
  end

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_s   = report_valid & report_ready;
  // a pop in the same cycle frees the slot being written, so full only blocks without one
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  assign report_valid = ~empty_s;
  assign report_id    = mem_r[rd_ptr_r[PTR_W-1:0]][ID_W-1:0];
  assign report_last  = mem_r[rd_ptr_r[PTR_W-1:0]][ID_W];

  // Report FIFO storage and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= {push_last_s, push_id_s};
        wr_ptr_r                   <= wr_ptr_r + (PTR_W+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_pl_kernel_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (PROC_NUM=4, FIFO_DEPTH=4, TIMEOUT=8).
module tb_pl_kernel_hls_deadlock_report_ctrl;

  logic       reset, clock;
  logic [3:0] dl_in_vec, token_vec, origin;
  logic       dl_detect, token_clear, report_valid, report_ready, report_last;
  logic [1:0] report_id;
  logic       trace_done, err_multi_token, err_timeout, err_overflow;
  int         checks, errors;

  pl_kernel_hls_deadlock_report_ctrl #(
    .PROC_NUM(4), .ID_W(2), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .reset(reset), .clock(clock), .dl_in_vec(dl_in_vec), .token_vec(token_vec),
    .dl_detect(dl_detect), .origin(origin), .token_clear(token_clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_id(report_id),
    .report_last(report_last), .trace_done(trace_done), .err_multi_token(err_multi_token),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic restart();
    @(negedge clock);
    reset = 1'b0; dl_in_vec = 4'b0000; token_vec = 4'b0000; report_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; dl_in_vec = 4'b1111; token_vec = 4'b1111; report_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({dl_detect, origin, token_clear, report_valid, report_id, report_last, trace_done,
         err_multi_token, err_timeout, err_overflow} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got dl=%b org=%b tc=%b v=%b id=%0d l=%b done=%b errs=%b%b%b expected all 0",
               dl_detect, origin, token_clear, report_valid, report_id, report_last, trace_done,
               err_multi_token, err_timeout, err_overflow);
    end
    reset = 1'b1; token_vec = 4'b0000;
    @(negedge clock);
    checks++;
    if ({report_valid, report_id, report_last, dl_detect, origin} !== {1'b1, 2'd0, 1'b0, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL reset_release_origin: got v=%b id=%0d l=%b dl=%b org=%b expected v=1 id=0 l=0 dl=1 org=0001",
               report_valid, report_id, report_last, dl_detect, origin);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({dl_detect, origin, report_valid, report_id} !== 8'd0) begin
      errors++;
      $display("FAIL reset_midtrace: got dl=%b org=%b v=%b id=%0d expected all 0",
               dl_detect, origin, report_valid, report_id);
    end
  endtask

  task automatic test_three_cycle();
    logic [1:0] exp_id [4];
    logic       exp_last [4];
    exp_id   = '{2'd2, 2'd1, 2'd3, 2'd2};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    restart();
    dl_in_vec = 4'b0100;
    @(negedge clock);
    checks++;
    if ({dl_detect, origin, report_valid, report_id} !== {1'b1, 4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL cyc_origin: got dl=%b org=%b v=%b id=%0d expected dl=1 org=0100 v=1 id=2",
               dl_detect, origin, report_valid, report_id);
    end
    @(negedge clock);
    token_vec = 4'b0010;
    #1;
    checks++;
    if ({origin, token_clear, dl_detect} !== {4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL cyc_hop1: got org=%b tc=%b dl=%b expected org=0000 tc=0 dl=1", origin, token_clear, dl_detect);
    end
    @(negedge clock);
    token_vec = 4'b1000;
    #1;
    checks++;
    if (token_clear !== 1'b0) begin
      errors++;
      $display("FAIL cyc_hop2_tc: got %b expected 0", token_clear);
    end
    @(negedge clock);
    checks++;
    if (trace_done !== 1'b0) begin
      errors++;
      $display("FAIL cyc_done_early: got %b expected 0", trace_done);
    end
    token_vec = 4'b0100;
    #1;
    checks++;
    if (token_clear !== 1'b1) begin
      errors++;
      $display("FAIL cyc_close_tc: got %b expected 1", token_clear);
    end
    @(negedge clock);
    token_vec = 4'b0100;
    #1;
    checks++;
    if ({trace_done, token_clear, err_overflow, err_timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL cyc_done: got done=%b tc=%b ovf=%b to=%b expected done=1 tc=0 ovf=0 to=0",
               trace_done, token_clear, err_overflow, err_timeout);
    end
    token_vec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({report_valid, report_id, report_last} !== {1'b1, exp_id[i], exp_last[i]}) begin
        errors++;
        $display("FAIL cyc_fifo_%0d: got v=%b id=%0d l=%b expected v=1 id=%0d l=%b",
                 i, report_valid, report_id, report_last, exp_id[i], exp_last[i]);
      end
      report_ready = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (report_valid !== 1'b0) begin
      errors++;
      $display("FAIL cyc_fifo_empty: got %b expected 0", report_valid);
    end
  endtask

  task automatic test_multi_token();
    restart();
    dl_in_vec = 4'b0001;
    @(negedge clock);
    dl_in_vec = 4'b0000;
    @(negedge clock);
    token_vec = 4'b0011;
    @(negedge clock);
    token_vec = 4'b0000;
    checks++;
    if ({err_multi_token, trace_done} !== 2'b10) begin
      errors++;
      $display("FAIL multi_flag: got multi=%b done=%b expected multi=1 done=0", err_multi_token, trace_done);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({report_valid, report_id, report_last} !== {1'b1, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL multi_fifo_%0d: got v=%b id=%0d l=%b expected v=1 id=0 l=0",
                 i, report_valid, report_id, report_last);
      end
      report_ready = 1'b1;
      @(negedge clock);
    end
  endtask

  task automatic test_timeout();
    restart();
    dl_in_vec = 4'b1000;
    @(negedge clock);
    dl_in_vec = 4'b0000;
    repeat (8) @(negedge clock);
    checks++;
    if ({err_timeout, trace_done} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_early: got to=%b done=%b expected 00", err_timeout, trace_done);
    end
    @(negedge clock);
    checks++;
    if ({err_timeout, trace_done, report_valid, report_id, report_last} !== {1'b1, 1'b1, 1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL timeout_fire: got to=%b done=%b v=%b id=%0d l=%b expected to=1 done=1 v=1 id=3 l=0",
               err_timeout, trace_done, report_valid, report_id, report_last);
    end
    report_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (report_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_single_entry: got v=%b expected 0", report_valid);
    end
  endtask

  task automatic test_backpressure(input bit ready_on_full);
    logic [3:0] tok [6];
    logic [1:0] exp_id [4];
    logic       exp_last [4];
    tok = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
    if (ready_on_full) begin
      exp_id   = '{2'd2, 2'd3, 2'd1, 2'd0};
      exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3};
      exp_last = '{1'b0, 1'b0, 1'b0, 1'b0};
    end
    restart();
    dl_in_vec = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      token_vec = tok[k];
      if (ready_on_full && k >= 4) report_ready = 1'b1;
    end
    @(negedge clock);
    token_vec = 4'b0000;
    checks++;
    if ({trace_done, err_overflow} !== {1'b1, ~ready_on_full}) begin
      errors++;
      $display("FAIL bp_flags_r%0d: got done=%b ovf=%b expected done=1 ovf=%b",
               ready_on_full, trace_done, err_overflow, ~ready_on_full);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({report_valid, report_id, report_last} !== {1'b1, exp_id[i], exp_last[i]}) begin
        errors++;
        $display("FAIL bp_fifo_r%0d_%0d: got v=%b id=%0d l=%b expected v=1 id=%0d l=%b",
                 ready_on_full, i, report_valid, report_id, report_last, exp_id[i], exp_last[i]);
      end
      report_ready = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (report_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty_r%0d: got v=%b expected 0", ready_on_full, report_valid);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; dl_in_vec = 4'b0000; token_vec = 4'b0000; report_ready = 1'b0;
    test_reset();
    test_three_cycle();
    test_multi_token();
    test_timeout();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
